// File: rtl/universal_shift_register_if.sv
// Bus bundle for universal_shift_register: control/data in, register state out.
// Optional rotate control present only when USR_ROTATE_EN is defined.
interface universal_shift_register_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       mode;
   logic [WIDTH-1:0] in;
   logic             si_msb;
   logic             si_lsb;
`ifdef USR_ROTATE_EN
   logic             rotate;
`endif
   logic [WIDTH-1:0] out;
   logic             so_lsb;
   logic             so_msb;
   logic [CW-1:0]    shift_count;
   logic             done;

   // Requester side: drives operation, observes register state
   modport master (
`ifdef USR_ROTATE_EN
      output rotate,
`endif
      output mode, in, si_msb, si_lsb,
      input  out, so_lsb, so_msb, shift_count, done
   );

   // Register side
   modport slave (
`ifdef USR_ROTATE_EN
      input  rotate,
`endif
      input  mode, in, si_msb, si_lsb,
      output out, so_lsb, so_msb, shift_count, done
   );
endinterface

// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit register with hold / shift right /
// shift left / parallel load, serial taps at both ends and a saturating
// shift counter with done level. Synchronous active-high reset.
// Optional feature macro: USR_ROTATE_EN (adds rotate control; serial
// inputs replaced by the bit wrapping around from the opposite end).

// One storage bit: picks its next value from itself, its upper neighbour
// (right shift), its lower neighbour (left shift) or the load data.
module usr_bit_cell (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] mode,
   input  logic       d_load,
   input  logic       d_hi,
   input  logic       d_lo,
   output logic       q
);
   // Per-bit state update; reset beats every mode
   always_ff @(posedge clk) begin
      if (reset) q <= 1'b0;
      else begin
         case (mode)
            2'b00:   q <= q;
            2'b01:   q <= d_hi;
            2'b10:   q <= d_lo;
            default: q <= d_load;
         endcase
      end
   end
endmodule

module universal_shift_register #(
   parameter int WIDTH = 4,
   localparam int CW   = $clog2(WIDTH + 1)
) (
   input logic                    clk,
   input logic                    reset,
   universal_shift_register_if.slave bus
);
   localparam logic [1:0] M_HOLD  = 2'b00;
   localparam logic [1:0] M_RIGHT = 2'b01;
   localparam logic [1:0] M_LEFT  = 2'b10;
   localparam logic [1:0] M_LOAD  = 2'b11;

   logic [WIDTH-1:0] q;
   logic [CW-1:0]    cnt;
   logic             msb_fill;
   logic             lsb_fill;

   // Bits entering at each end: serial inputs, or the wrapped bit when rotating
`ifdef USR_ROTATE_EN
   always_comb begin
      msb_fill = bus.rotate ? q[0]       : bus.si_msb;
      lsb_fill = bus.rotate ? q[WIDTH-1] : bus.si_lsb;
   end
`else
   always_comb begin
      msb_fill = bus.si_msb;
      lsb_fill = bus.si_lsb;
   end
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic d_hi;
      logic d_lo;
      if (i == WIDTH - 1) begin : g_top
         assign d_hi = msb_fill;
      end else begin : g_mid_hi
         assign d_hi = q[i+1];
      end
      if (i == 0) begin : g_bot
         assign d_lo = lsb_fill;
      end else begin : g_mid_lo
         assign d_lo = q[i-1];
      end
      usr_bit_cell u_cell (
         .clk    (clk),
         .reset  (reset),
         .mode   (bus.mode),
         .d_load (bus.in[i]),
         .d_hi   (d_hi),
         .d_lo   (d_lo),
         .q      (q[i])
      );
   end

   // Shift counter: cleared by reset/load, saturates at WIDTH, hold leaves it
   always_ff @(posedge clk) begin
      if (reset) cnt <= '0;
      else begin
         case (bus.mode)
            M_LOAD:         cnt <= '0;
            M_RIGHT,
            M_LEFT:         if (cnt != CW'(WIDTH)) cnt <= cnt + 1'b1;
            M_HOLD:         cnt <= cnt;
            default:        cnt <= cnt;
         endcase
      end
   end

   assign bus.out         = q;
   assign bus.so_lsb      = q[0];
   assign bus.so_msb      = q[WIDTH-1];
   assign bus.shift_count = cnt;
   assign bus.done        = (cnt == CW'(WIDTH));
endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=4): directed
// plan with literal expectations, then randomized traffic against an
// arithmetic reference model compared every cycle.
module tb_universal_shift_register;
   localparam int W  = 4;
   localparam int CW = $clog2(W + 1);

   logic clk = 1'b0;
   logic reset;
   logic [1:0]   md;
   logic [W-1:0] din;
   logic sm, sl, rot;

   int checks = 0;
   int errors = 0;
   bit armed  = 0;

   // Reference model state
   int m_out = 0;
   int m_cnt = 0;

   universal_shift_register_if #(.WIDTH(W)) bus ();
   assign bus.mode   = md;
   assign bus.in     = din;
   assign bus.si_msb = sm;
   assign bus.si_lsb = sl;
`ifdef USR_ROTATE_EN
   assign bus.rotate = rot;
`endif

   universal_shift_register #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: integer arithmetic on the register value
   always @(posedge clk) begin
      int fill;
      if (reset) begin
         m_out = 0; m_cnt = 0; armed = 1;
      end else begin
         case (md)
            2'b01: begin
               fill  = rot ? (m_out & 1) : int'(sm);
               m_out = (m_out >> 1) + fill * (1 << (W - 1));
               if (m_cnt < W) m_cnt = m_cnt + 1;
            end
            2'b10: begin
               fill  = rot ? ((m_out >> (W - 1)) & 1) : int'(sl);
               m_out = ((m_out * 2) % (1 << W)) + fill;
               if (m_cnt < W) m_cnt = m_cnt + 1;
            end
            2'b11: begin
               m_out = int'(din); m_cnt = 0;
            end
            default: ;
         endcase
      end
   end

   // Every-cycle comparison, away from the active edge
   always @(negedge clk) begin
      if (armed) begin
         chk("out",   int'(bus.out), m_out);
         chk("so_lsb", int'(bus.so_lsb), m_out & 1);
         chk("so_msb", int'(bus.so_msb), (m_out >> (W - 1)) & 1);
         chk("shift_count", int'(bus.shift_count), m_cnt);
         chk("done",  int'(bus.done), (m_cnt == W) ? 1 : 0);
      end
   end

   // Apply one set of inputs across exactly one rising edge
   task automatic cyc(input logic r, input logic [1:0] m, input logic [W-1:0] d,
                      input logic s_m, input logic s_l, input logic ro);
      reset = r; md = m; din = d; sm = s_m; sl = s_l; rot = ro;
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string name, input int exp_out, input int exp_cnt, input int exp_done);
      chk({name, "_out"},  int'(bus.out), exp_out);
      chk({name, "_cnt"},  int'(bus.shift_count), exp_cnt);
      chk({name, "_done"}, int'(bus.done), exp_done);
      chk({name, "_model"}, m_out, exp_out);
   endtask

   initial begin
      // Reset beats load
      cyc(1, 2'b11, 4'b1111, 0, 0, 0);
      cyc(1, 2'b11, 4'b1111, 0, 0, 0);
      lit("reset", 'b0000, 0, 0);
      chk("reset_so", int'({bus.so_msb, bus.so_lsb}), 0);

      // Load then hold
      cyc(0, 2'b11, 4'b0101, 0, 0, 0);
      lit("load0101", 'b0101, 0, 0);
      repeat (3) cyc(0, 2'b00, 4'b1010, 1, 1, 0);
      lit("hold", 'b0101, 0, 0);

      // Right shift then left shift
      chk("so_lsb_pre", int'(bus.so_lsb), 1);
      cyc(0, 2'b01, 4'b0000, 1, 0, 0);
      lit("shr", 'b1010, 1, 0);
      cyc(0, 2'b10, 4'b0000, 1, 0, 0);
      lit("shl", 'b0100, 2, 0);

      // Saturation and done
      cyc(0, 2'b11, 4'b1001, 0, 0, 0);
      repeat (4) cyc(0, 2'b01, 4'b0000, 0, 0, 0);
      lit("sat4", 'b0000, 4, 1);
      cyc(0, 2'b01, 4'b0000, 0, 0, 0);
      lit("sat5", 'b0000, 4, 1);
      cyc(0, 2'b11, 4'b0011, 0, 0, 0);
      lit("reload", 'b0011, 0, 0);

      // Mid-sequence reset
      cyc(0, 2'b11, 4'b1111, 0, 0, 0);
      repeat (2) cyc(0, 2'b10, 4'b0000, 0, 0, 0);
      lit("pre_rst", 'b1100, 2, 0);
      cyc(1, 2'b01, 4'b0000, 1, 1, 0);
      lit("mid_rst", 'b0000, 0, 0);
      cyc(0, 2'b11, 4'b0110, 0, 0, 0);
      lit("post_rst", 'b0110, 0, 0);

`ifdef USR_ROTATE_EN
      cyc(0, 2'b11, 4'b0001, 0, 0, 0);
      cyc(0, 2'b01, 4'b0000, 0, 0, 1);
      lit("rotr", 'b1000, 1, 0);
      cyc(0, 2'b10, 4'b0000, 0, 0, 1);
      lit("rotl", 'b0001, 2, 0);
`endif

      // Randomized traffic, checked every cycle by the model comparison
      for (int n = 0; n < 3000; n++) begin
         logic ro;
`ifdef USR_ROTATE_EN
         ro = 1'($urandom_range(0, 1));
`else
         ro = 1'b0;
`endif
         cyc(($urandom_range(0, 39) == 0), 2'($urandom), W'($urandom),
             1'($urandom), 1'($urandom), ro);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
